tx_block: RTL and testbench

//   UART-style serial transmitter and companion to the receiver path.

---
 rtl/tx_block.sv | 179 +++++++++++++++++
 tb/tb_tx_block.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tx_block.sv
// UART-style 8N1 serial transmitter with a 1-entry holding buffer and sticky overrun flag.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module tx_block #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] tx_data,
   input  logic       load_data,
   input  logic       clr_error,
   output logic       serial_out,
   output logic       tx_busy,
   output logic       buffer_full,
   output logic       overrun_error
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif

   logic [2:0]       state, state_next;
   logic [CNT_W-1:0] clk_cnt, cnt_next;
   logic [2:0]       bit_cnt, bit_next;
   logic [7:0]       shift_reg, shift_next;
   logic [7:0]       hold_reg;
   logic             out_next;
   logic             take_buf;
   logic             cnt_last;
   logic             load_ok;
`ifdef TX_PARITY_EN
   logic             parity_bit;
`endif

   assign cnt_last = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign tx_busy  = (state != ST_IDLE);
   assign load_ok  = load_data && (!buffer_full || take_buf);

   // Next-state logic; serial_out is computed from the next state so the line flop changes
   // on the same edge as the FSM and never lags it by a cycle.
   always_comb begin
      state_next = state;
      cnt_next   = clk_cnt;
      bit_next   = bit_cnt;
      shift_next = shift_reg;
      out_next   = serial_out;
      take_buf   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_next = '0;
            bit_next = '0;
            out_next = 1'b1;
            if (buffer_full) begin
               take_buf   = 1'b1;
               shift_next = hold_reg;
               state_next = ST_START;
               out_next   = 1'b0;
            end
         end
         ST_START: begin
            if (cnt_last) begin
               cnt_next   = '0;
               state_next = ST_DATA;
               out_next   = shift_reg[0];
            end else begin
               cnt_next = clk_cnt + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_last) begin
               cnt_next = '0;
               if (bit_cnt == 3'd7) begin
                  bit_next = '0;
`ifdef TX_PARITY_EN
                  state_next = ST_PARITY;
                  out_next   = parity_bit;
`else
                  state_next = ST_STOP;
                  out_next   = 1'b1;
`endif
               end else begin
                  bit_next   = bit_cnt + 1'b1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  out_next   = shift_reg[1];
               end
            end else begin
               cnt_next = clk_cnt + 1'b1;
            end
         end
`ifdef TX_PARITY_EN
         ST_PARITY: begin
            if (cnt_last) begin
               cnt_next   = '0;
               state_next = ST_STOP;
               out_next   = 1'b1;
            end else begin
               cnt_next = clk_cnt + 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_last) begin
               cnt_next = '0;
               // Back-to-back frames: a waiting byte goes straight into a new start bit.
               if (buffer_full) begin
                  take_buf   = 1'b1;
                  shift_next = hold_reg;
                  state_next = ST_START;
                  out_next   = 1'b0;
               end else begin
                  state_next = ST_IDLE;
                  out_next   = 1'b1;
               end
            end else begin
               cnt_next = clk_cnt + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            bit_next   = '0;
            out_next   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= ST_IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         serial_out <= 1'b1;
      end else begin
         state      <= state_next;
         clk_cnt    <= cnt_next;
         bit_cnt    <= bit_next;
         shift_reg  <= shift_next;
         serial_out <= out_next;
      end
   end

   // Holding buffer: a load may refill it on the very edge the FSM drains it.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hold_reg      <= '0;
         buffer_full   <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         if (load_ok) begin
            hold_reg    <= tx_data;
            buffer_full <= 1'b1;
         end else if (take_buf) begin
            buffer_full <= 1'b0;
         end
         if (load_data && !load_ok) begin
            overrun_error <= 1'b1;
         end else if (clr_error) begin
            overrun_error <= 1'b0;
         end
      end
   end

`ifdef TX_PARITY_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         parity_bit <= 1'b0;
      end else if (take_buf) begin
         parity_bit <= ^hold_reg;
      end
   end
`endif

endmodule

// File: tb/tb_tx_block.sv
// Directed testbench for tx_block: reset, single frames, back-to-back frames, overrun, mid-frame reset.
// Frame length and expected bits follow TX_PARITY_EN when it is defined.
module tb_tx_block;

   localparam int CPB = 10;
`ifdef TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       clk;
   logic       n_rst;
   logic [7:0] tx_data;
   logic       load_data;
   logic       clr_error;
   logic       serial_out;
   logic       tx_busy;
   logic       buffer_full;
   logic       overrun_error;

   int checkCount = 0;
   int failCount  = 0;

   tx_block #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .tx_data      (tx_data),
      .load_data    (load_data),
      .clr_error    (clr_error),
      .serial_out   (serial_out),
      .tx_busy      (tx_busy),
      .buffer_full  (buffer_full),
      .overrun_error(overrun_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] data);
      tx_data   = data;
      load_data = 1'b1;
      tick();
      load_data = 1'b0;
   endtask

   task automatic releaseReset();
      @(posedge clk);
      #2 n_rst = 1'b1;
      tick();
   endtask

   // Walks one frame cycle by cycle from startCycle; optionally loads loadByte at cycle loadAt.
   task automatic checkFrame(input logic [7:0] data, input int startCycle, input int loadAt,
                             input logic [7:0] loadByte);
      logic [FRAME_BITS-1:0] bits;
`ifdef TX_PARITY_EN
      bits = {1'b1, ^data, data, 1'b0};
`else
      bits = {1'b1, data, 1'b0};
`endif
      for (int c = startCycle; c < FRAME_BITS * CPB; c++) begin
         checkOutput($sformatf("line_%0h_c%0d", data, c), {31'd0, serial_out}, {31'd0, bits[c / CPB]});
         checkOutput($sformatf("busy_%0h_c%0d", data, c), {31'd0, tx_busy}, 32'd1);
         if (c == loadAt) begin
            applyStimulus(loadByte);
            checkOutput($sformatf("bufload_%0h", loadByte), {31'd0, buffer_full}, 32'd1);
         end else begin
            tick();
         end
      end
   endtask

   initial begin
      n_rst     = 1'b1;
      tx_data   = 8'h00;
      load_data = 1'b0;
      clr_error = 1'b0;

      #2 n_rst = 1'b0;
      #1;
      checkOutput("rst_serial", {31'd0, serial_out}, 32'd1);
      checkOutput("rst_busy", {31'd0, tx_busy}, 32'd0);
      checkOutput("rst_buf", {31'd0, buffer_full}, 32'd0);
      checkOutput("rst_ovr", {31'd0, overrun_error}, 32'd0);
      releaseReset();

      // Reset in idle with a byte parked in the buffer clears it without a clock edge.
      applyStimulus(8'h5A);
      checkOutput("t1_buf_before", {31'd0, buffer_full}, 32'd1);
      #2 n_rst = 1'b0;
      #1;
      checkOutput("t1_serial", {31'd0, serial_out}, 32'd1);
      checkOutput("t1_busy", {31'd0, tx_busy}, 32'd0);
      checkOutput("t1_buf", {31'd0, buffer_full}, 32'd0);
      checkOutput("t1_ovr", {31'd0, overrun_error}, 32'd0);
      releaseReset();
      checkOutput("t1_idle_after", {31'd0, serial_out}, 32'd1);

      // Single frame 8'hA5.
      applyStimulus(8'hA5);
      checkOutput("t2_buf", {31'd0, buffer_full}, 32'd1);
      checkOutput("t2_idle_line", {31'd0, serial_out}, 32'd1);
      tick();
      checkOutput("t2_buf_drained", {31'd0, buffer_full}, 32'd0);
      checkFrame(8'hA5, 0, -1, 8'h00);
      checkOutput("t2_end_busy", {31'd0, tx_busy}, 32'd0);
      checkOutput("t2_end_line", {31'd0, serial_out}, 32'd1);
      tick();

      // Back-to-back: 8'h55 then 8'h0F loaded mid-frame.
      applyStimulus(8'h55);
      tick();
      checkFrame(8'h55, 0, 20, 8'h0F);
      checkOutput("t3_no_gap_line", {31'd0, serial_out}, 32'd0);
      checkOutput("t3_no_gap_busy", {31'd0, tx_busy}, 32'd1);
      checkOutput("t3_buf_drop", {31'd0, buffer_full}, 32'd0);
      checkFrame(8'h0F, 0, -1, 8'h00);
      checkOutput("t3_end_busy", {31'd0, tx_busy}, 32'd0);
      tick();

      // Overrun: third consecutive load is dropped.
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      checkOutput("t4_ovr_set", {31'd0, overrun_error}, 32'd1);
      checkOutput("t4_buf_full", {31'd0, buffer_full}, 32'd1);
      checkFrame(8'h11, 1, -1, 8'h00);
      checkOutput("t4_buf_drain", {31'd0, buffer_full}, 32'd0);
      checkFrame(8'h22, 0, -1, 8'h00);
      checkOutput("t4_end_busy", {31'd0, tx_busy}, 32'd0);
      checkOutput("t4_ovr_sticky", {31'd0, overrun_error}, 32'd1);
      clr_error = 1'b1;
      tick();
      clr_error = 1'b0;
      checkOutput("t4_ovr_clr", {31'd0, overrun_error}, 32'd0);

      // Reset during data bit 3 of 8'hF0, with 8'h3C waiting in the buffer.
      applyStimulus(8'hF0);
      tick();
      for (int c = 0; c < 45; c++) begin
         if (c == 10) applyStimulus(8'h3C);
         else tick();
      end
      checkOutput("t5_bit3", {31'd0, serial_out}, 32'd0);
      checkOutput("t5_buf_before", {31'd0, buffer_full}, 32'd1);
      #2 n_rst = 1'b0;
      #1;
      checkOutput("t5_serial", {31'd0, serial_out}, 32'd1);
      checkOutput("t5_busy", {31'd0, tx_busy}, 32'd0);
      checkOutput("t5_buf", {31'd0, buffer_full}, 32'd0);
      releaseReset();
      for (int c = 0; c < 120; c++) begin
         checkOutput($sformatf("t5_idle_c%0d", c), {30'd0, serial_out, tx_busy}, 32'd2);
         tick();
      end

`ifdef TX_PARITY_EN
      // Parity frames: 8'h07 has odd weight (parity 1), 8'h03 even weight (parity 0).
      applyStimulus(8'h07);
      tick();
      checkFrame(8'h07, 0, -1, 8'h00);
      checkOutput("t6_end_busy_07", {31'd0, tx_busy}, 32'd0);
      applyStimulus(8'h03);
      tick();
      for (int c = 0; c < 90; c++) tick();
      checkOutput("t6_parity_03", {31'd0, serial_out}, 32'd0);
      for (int c = 90; c < 110; c++) tick();
      checkOutput("t6_end_busy_03", {31'd0, tx_busy}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
